instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-004 SHALL have port imem_addr  output  32  read address; equals PC while imem_req=1.
REQ-005 SHALL have port imem_ready  input  1  read data valid on imem_rdata this cycle.
REQ-006 SHALL have port imem_rdata  input  32  instruction word.
REQ-007 SHALL have port inst_valid  output  1  held instruction is valid for decode.
REQ-008 SHALL have port inst  output  32  held instruction word.
REQ-009 SHALL have port inst_pc  output  32  PC of the held instruction.
REQ-010 SHALL have port part_of_inst  output  7  inst[6:0] when inst_valid=1, else 7'b0; feeds the control unit.
REQ-011 SHALL have port inst_accept  input  1  downstream finished the held instruction.
REQ-012 SHALL have port redirect  input  1  taken jal/jalr/branch for the accepted instruction.
REQ-013 SHALL have port redirect_target  input  32  next PC when redirect=1.
REQ-014 SHALL have port halt  input  1  accepted instruction is a terminating ecall.
REQ-015 SHALL have port halted  output  1  fetch permanently stopped.
REQ-016 SHALL have port fetch_err  output  1  memory timeout flag (REQ-033).

Function
REQ-017 SHALL implement FSM states REQ, VALID, HALT.
REQ-018 REQ: imem_req=1, imem_addr=PC; on imem_ready=1 capture imem_rdata into inst, PC into inst_pc, go VALID next edge.
REQ-019 Minimum latency: imem_ready in first REQ cycle -> inst_valid=1 on the following cycle.
REQ-020 VALID: imem_req=0, inst_valid=1, inst/inst_pc stable until inst_accept=1.
REQ-021 VALID with inst_accept=1: halt=1 -> HALT; else redirect=1 -> PC=redirect_target with bits[1:0] forced 0, go REQ; else PC=inst_pc+4, go REQ.
REQ-022 halt and redirect simultaneous: halt wins, PC unchanged.
REQ-023 redirect, redirect_target, halt, inst_accept SHALL be ignored outside VALID.
REQ-024 imem_ready SHALL be ignored when imem_req=0.
REQ-025 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 HALT: absorbing until reset; imem_req=0, inst_valid=0, halted=1.
REQ-027 Only one request outstanding at any time; no prefetch.

Reset
REQ-028 reset_n=0 SHALL immediately force: state REQ, PC=32'h0, inst=32'h0, inst_pc=32'h0, inst_valid=0, halted=0, fetch_err=0, timeout counter=0.
REQ-029 imem_req SHALL be 0 while reset_n=0 and 1 from the first cycle after release.
REQ-030 Reset mid-request abandons the transaction; instruction memory shares reset_n, so no stale response is expected.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN SHALL compile in an 8-bit wait counter.
REQ-032 Counter: cleared on entry to REQ, increments each REQ cycle without imem_ready, saturates at 255.
REQ-033 With FETCH_TIMEOUT_EN: counter reaching 255 -> next state HALT with fetch_err=1 and halted=1. Without it: fetch_err tied 0, REQ waits indefinitely.

Structure
REQ-034 Shared package SHALL hold the fetch state encoding, RESET_PC=32'h0, PC_STEP=4, TIMEOUT_MAX=255; opcode constants remain in the existing opcodes include.
REQ-035 One sub-module, pc_register (32-bit PC, async active-low reset to RESET_PC, load enable, next-PC input), SHALL be instantiated; the FSM stays in the top.

Verification
REQ-036 Reset release, imem_ready same cycle, rdata=32'h00500093 -> imem_addr=0, next cycle inst_valid=1, part_of_inst=7'h13, inst_pc=0.
REQ-037 Accept without redirect at inst_pc=32'h10 -> next imem_addr=32'h14; accept with redirect, target 32'h103 -> next imem_addr=32'h100.
REQ-038 Accept with halt=1 and redirect=1 -> HALT, halted=1, imem_req=0, imem_ready pulses ignored for 20 cycles.
REQ-039 imem_ready delayed 5 cycles, inst_accept held 0 for 3 cycles in VALID -> imem_addr stable 6 cycles, inst stable 4 cycles, no second request.
REQ-040 PC=32'hFFFF_FFFC accepted without redirect -> next imem_addr=32'h0; reset_n pulsed low mid-REQ -> outputs immediately at reset values.
REQ-041 FETCH_TIMEOUT_EN defined, imem_ready never asserted -> fetch_err=1 and halted=1 after 255 REQ cycles; undefined -> imem_req remains 1, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset PC, sequential PC step and fetch-timeout limit.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_VALID = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [7:0]  TIMEOUT_MAX = 8'd255;

    // Force a byte address onto a 32-bit instruction boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register: 32-bit, async active-low reset to RESET_PC,
// loads pc_next when load_en is high, otherwise holds.
module pc_register
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_en,
    input  logic [31:0] pc_next,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Select between holding the current PC and loading the next one.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = pc_next;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM (REQ, VALID,
// HALT) holding one instruction for decode until it is accepted.
// Optional build macro FETCH_TIMEOUT_EN adds an 8-bit wait counter that
// halts fetch with fetch_err when memory never answers.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  part_of_inst,
    input  logic        inst_accept,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_e state_d, state_q;
    logic [31:0]  inst_d, inst_q;
    logic [31:0]  inst_pc_d, inst_pc_q;
    logic         imem_req_d, imem_req_q;
    logic         inst_valid_d, inst_valid_q;
    logic         halted_d, halted_q;
    logic [6:0]   part_d, part_q;
    logic         pc_load_s;
    logic [31:0]  pc_next_s;
    logic [31:0]  pc_s;
`ifdef FETCH_TIMEOUT_EN
    logic [7:0]   cnt_d, cnt_q;
    logic         fetch_err_d, fetch_err_q;
`endif

    pc_register u_pc_register (
        .clk     (clk),
        .reset_n (reset_n),
        .load_en (pc_load_s),
        .pc_next (pc_next_s),
        .pc      (pc_s)
    );

    // Fetch FSM next-state, capture and PC-update logic; the registered
    // outputs are decoded from the next state so they change with it.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_load_s = 1'b0;
        pc_next_s = pc_s;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            ST_REQ: begin
                // imem_req_q is low only in the partial cycle right after
                // reset release; a response there is not ours.
                if (imem_req_q && imem_ready) begin
                    state_d   = ST_VALID;
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_s;
                end else if (imem_req_q) begin
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = (cnt_q == TIMEOUT_MAX) ? cnt_q : cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_MAX) begin
                        state_d     = ST_HALT;
                        fetch_err_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_VALID: begin
                if (inst_accept) begin
                    if (halt) begin
                        // Halt has priority over redirect; PC stays put.
                        state_d = ST_HALT;
                    end else if (redirect) begin
                        state_d   = ST_REQ;
                        pc_load_s = 1'b1;
                        pc_next_s = align_word(redirect_target);
                    end else begin
                        state_d   = ST_REQ;
                        pc_load_s = 1'b1;
                        pc_next_s = inst_pc_q + PC_STEP;
                    end
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        imem_req_d   = (state_d == ST_REQ);
        inst_valid_d = (state_d == ST_VALID);
        halted_d     = (state_d == ST_HALT);
        part_d       = inst_valid_d ? inst_d[6:0] : 7'b000_0000;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_REQ;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            part_q       <= 7'b000_0000;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            part_q       <= part_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_s;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign part_of_inst = part_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory/consumer driver with a
// behavioural PC model pushes expected instructions; a monitor pops and
// compares whenever a new instruction appears on the decode side.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  part_of_inst;
    logic        inst_accept;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_pc;
    logic        prev_valid;
    logic [31:0] held_inst;
    logic [31:0] held_pc;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .part_of_inst    (part_of_inst),
        .inst_accept     (inst_accept),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: score each newly presented instruction and its stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_inst", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst", inst, mon_e.word);
                    chk("inst_pc", inst_pc, mon_e.pc);
                    chk("part_of_inst", {25'd0, part_of_inst}, {25'd0, mon_e.word[6:0]});
                end
                held_inst <= inst;
                held_pc   <= inst_pc;
            end else if (inst_valid) begin
                chk("inst_stable", inst, held_inst);
                chk("inst_pc_stable", inst_pc, held_pc);
            end else begin
                chk("part_zero", {25'd0, part_of_inst}, 32'd0);
            end
            prev_valid <= inst_valid;
        end
    end

    task automatic idle_inputs();
        imem_ready  = 1'b0;
        inst_accept = 1'b0;
        redirect    = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_part", {25'd0, part_of_inst}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        exp_q.delete();
        exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_after_reset", {31'd0, imem_req}, 32'd1);
    endtask

    // One complete fetch transaction with memory delay dly and consumer
    // delay acc_dly; unrelated inputs are randomised where they must be ignored.
    task automatic fetch(input int dly, input logic [31:0] data, input int acc_dly,
                         input logic redir, input logic [31:0] tgt, input logic hlt);
        int waited;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        chk("imem_addr", imem_addr, exp_pc);
        for (int i = 0; i < dly; i++) begin
            imem_ready      = 1'b0;
            imem_rdata      = $urandom;
            inst_accept     = 1'($urandom);
            redirect        = 1'($urandom);
            halt            = 1'($urandom);
            redirect_target = $urandom;
            @(posedge clk);
            #1;
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, exp_pc);
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        exp_q.push_back('{data, exp_pc});
        @(posedge clk);
        #1;
        idle_inputs();
        imem_rdata = $urandom;
        chk("inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("no_req_in_valid", {31'd0, imem_req}, 32'd0);
        for (int j = 0; j < acc_dly; j++) begin
            redirect   = 1'($urandom);
            halt       = 1'($urandom);
            imem_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk("no_second_req", {31'd0, imem_req}, 32'd0);
            chk("valid_held", {31'd0, inst_valid}, 32'd1);
        end
        inst_accept     = 1'b1;
        redirect        = redir;
        halt            = hlt;
        redirect_target = tgt;
        imem_ready      = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        if (hlt) begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            chk("halt_no_valid", {31'd0, inst_valid}, 32'd0);
        end else begin
            if (redir) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
            chk("next_req", {31'd0, imem_req}, 32'd1);
            chk("next_addr", imem_addr, exp_pc);
            chk("valid_drop", {31'd0, inst_valid}, 32'd0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then randomised traffic.
    initial begin : stim
        imem_rdata      = 32'h0;
        redirect_target = 32'h0;
        prev_valid      = 1'b0;
        held_inst       = 32'h0;
        held_pc         = 32'h0;
        exp_pc          = 32'h0;
        do_reset();

        // First instruction with zero memory latency.
        fetch(0, 32'h0050_0093, 0, 1'b0, 32'h0, 1'b0);

        // Sequential fetches up to 0x10, then step to 0x14 and redirect.
        for (int k = 0; k < 3; k++) begin
            fetch($urandom_range(0, 2), $urandom, 0, 1'b0, 32'h0, 1'b0);
        end
        fetch(0, $urandom, 0, 1'b0, 32'h0, 1'b0);
        chk("seq_addr_14", imem_addr, 32'h14);
        fetch(0, $urandom, 0, 1'b1, 32'h103, 1'b0);
        chk("redir_addr_100", imem_addr, 32'h100);

        // Slow memory and slow consumer.
        fetch(5, $urandom, 3, 1'b0, 32'h0, 1'b0);

        // PC wrap from the top of the address space.
        fetch(1, $urandom, 0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(1, $urandom, 0, 1'b0, 32'h0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomised traffic.
        for (int k = 0; k < 40; k++) begin
            fetch($urandom_range(0, 4), $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        // Reset in the middle of a pending request.
        @(posedge clk);
        #2;
        do_reset();

        // Halt wins over redirect; HALT ignores memory responses.
        fetch(1, $urandom, 1, 1'b1, 32'h200, 1'b1);
        for (int k = 0; k < 20; k++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            @(posedge clk);
            #1;
            chk("halt_sticky", {31'd0, halted}, 32'd1);
            chk("halt_req_low", {31'd0, imem_req}, 32'd0);
            chk("halt_pc_kept", imem_addr, exp_pc);
        end
        do_reset();

        // Memory never answers.
        fetch(0, $urandom, 0, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        repeat (254) begin
            @(posedge clk);
            #1;
        end
        chk("no_early_timeout", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        chk("timeout_err", {31'd0, fetch_err}, 32'd1);
        chk("timeout_req_low", {31'd0, imem_req}, 32'd0);
`else
        repeat (300) begin
            @(posedge clk);
            #1;
        end
        chk("wait_req_held", {31'd0, imem_req}, 32'd1);
        chk("wait_no_err", {31'd0, fetch_err}, 32'd0);
        chk("wait_not_halted", {31'd0, halted}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
